// File: rtl/sequence_packer.sv
// Packs one sequence step into a 128-bit word and writes it to BRAM as four 32-bit beats.
// Optional DAC clamping and saturation counting: define SEQ_PACK_SATURATE_EN.
module sequence_packer #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [15:0]           dac_value_0,
  input  logic [15:0]           dac_value_1,
  input  logic [10:0]           pdm_value_0,
  input  logic [10:0]           pdm_value_1,
  input  logic [10:0]           pdm_value_2,
  input  logic [10:0]           pdm_value_3,
  input  logic [1:0]            enable_dac,
  input  logic [3:0]            enable_pdm,
  input  logic [1:0]            enable_dac_ramp_down,
  input  logic                  restart,
  input  logic [ADDR_WIDTH-3:0] start_step,
  output logic                  bram_en,
  output logic [3:0]            bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [31:0]           bram_din,
  output logic [ADDR_WIDTH-3:0] step_ptr,
  output logic                  step_done,
  output logic [15:0]           sat_count
);

  localparam int PW = ADDR_WIDTH - 2;

  typedef enum logic [2:0] {IDLE, W0, W1, W2, W3} state_t;

  state_t          r_state;
  logic [127:0]    r_word;
  logic [PW-1:0]   r_step_ptr;
  logic            r_pend;
  logic [PW-1:0]   r_pend_step;
  logic            r_s_ready;
  logic            r_bram_en;
  logic [3:0]      r_bram_we;
  logic [ADDR_WIDTH-1:0] r_bram_addr;
  logic [31:0]     r_bram_din;
  logic            r_step_done;

  logic [13:0]     w_dac0_14;
  logic [13:0]     w_dac1_14;
  logic            w_sat0;
  logic            w_sat1;
  logic [127:0]    w_word;
  logic            w_hs;
  logic            w_take;
  logic [PW-1:0]   w_ptr_idle;
  logic [PW-1:0]   w_ptr_w3;

`ifdef SEQ_PACK_SATURATE_EN
  logic w_hi0, w_lo0, w_hi1, w_lo1;
  assign w_hi0 = ($signed(dac_value_0) > $signed(16'sd8191));
  assign w_lo0 = ($signed(dac_value_0) < $signed(-16'sd8192));
  assign w_hi1 = ($signed(dac_value_1) > $signed(16'sd8191));
  assign w_lo1 = ($signed(dac_value_1) < $signed(-16'sd8192));
  assign w_sat0 = w_hi0 | w_lo0;
  assign w_sat1 = w_hi1 | w_lo1;
  assign w_dac0_14 = w_hi0 ? 14'h1FFF : (w_lo0 ? 14'h2000 : dac_value_0[13:0]);
  assign w_dac1_14 = w_hi1 ? 14'h1FFF : (w_lo1 ? 14'h2000 : dac_value_1[13:0]);
`else
  logic [3:0] w_unused_dac_hi;
  assign w_unused_dac_hi = {dac_value_0[15:14], dac_value_1[15:14]};
  assign w_sat0 = 1'b0;
  assign w_sat1 = 1'b0;
  assign w_dac0_14 = dac_value_0[13:0];
  assign w_dac1_14 = dac_value_1[13:0];
`endif

  assign w_word = {14'b0, enable_dac_ramp_down[1], enable_dac_ramp_down[0], 10'b0,
                   enable_pdm, enable_dac,
                   5'b0, pdm_value_3, 5'b0, pdm_value_2,
                   5'b0, pdm_value_1, 5'b0, pdm_value_0,
                   {2{w_dac1_14[13]}}, w_dac1_14,
                   {2{w_dac0_14[13]}}, w_dac0_14};

  assign w_hs   = s_valid & r_s_ready;
  assign w_take = w_hs & ((r_state == IDLE) | (r_state == W3));

  // A restart in the last beat wins over any earlier pending one and over the increment.
  assign w_ptr_idle = restart ? start_step : r_step_ptr;
  assign w_ptr_w3   = restart ? start_step : (r_pend ? r_pend_step : r_step_ptr + PW'(1));

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_word      <= '0;
      r_step_ptr  <= '0;
      r_pend      <= 1'b0;
      r_pend_step <= '0;
      r_s_ready   <= 1'b0;
      r_bram_en   <= 1'b0;
      r_bram_we   <= 4'h0;
      r_bram_addr <= '0;
      r_bram_din  <= '0;
      r_step_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_step_ptr <= w_ptr_idle;
          if (w_hs) begin
            r_word      <= w_word;
            r_bram_en   <= 1'b1;
            r_bram_we   <= 4'hF;
            r_bram_addr <= {w_ptr_idle, 2'd0};
            r_bram_din  <= w_word[31:0];
            r_s_ready   <= 1'b0;
            r_state     <= W0;
          end else begin
            r_s_ready <= 1'b1;
          end
        end
        W0, W1, W2: begin
          if (restart) begin
            r_pend      <= 1'b1;
            r_pend_step <= start_step;
          end
          r_bram_addr[1:0] <= r_bram_addr[1:0] + 2'd1;
          case (r_state)
            W0:      begin r_bram_din <= r_word[63:32];  r_state <= W1; end
            W1:      begin r_bram_din <= r_word[95:64];  r_state <= W2; end
            default: begin
              r_bram_din  <= r_word[127:96];
              r_step_done <= 1'b1;
              r_s_ready   <= 1'b1;
              r_state     <= W3;
            end
          endcase
        end
        W3: begin
          r_step_done <= 1'b0;
          r_step_ptr  <= w_ptr_w3;
          r_pend      <= 1'b0;
          if (w_hs) begin
            r_word      <= w_word;
            r_bram_addr <= {w_ptr_w3, 2'd0};
            r_bram_din  <= w_word[31:0];
            r_s_ready   <= 1'b0;
            r_state     <= W0;
          end else begin
            r_bram_en <= 1'b0;
            r_bram_we <= 4'h0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_PACK_SATURATE_EN
  logic [15:0] r_sat_count;
  logic [16:0] w_sat_sum;
  assign w_sat_sum = {1'b0, r_sat_count} + {15'b0, w_sat0} + {15'b0, w_sat1};
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_sat_count <= '0;
    end else if (w_take) begin
      r_sat_count <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
    end
  end
  assign sat_count = r_sat_count;
`else
  logic w_unused_sat;
  assign w_unused_sat = w_sat0 | w_sat1 | w_take;
  assign sat_count = 16'h0000;
`endif

  assign s_ready   = r_s_ready;
  assign bram_en   = r_bram_en;
  assign bram_we   = r_bram_we;
  assign bram_addr = r_bram_addr;
  assign bram_din  = r_bram_din;
  assign step_ptr  = r_step_ptr;
  assign step_done = r_step_done;

endmodule
